// File: rtl/cci_mpf_csr_event_counter_bank.sv
// Event-counter bank: staged multi-bit increments, per-channel clear, atomic snapshot,
// sticky overflow and a two-stage MMIO read pipe.
module cci_mpf_csr_event_counter_bank #(
  parameter int N_EVENTS      = 8,
  parameter int INCR_WIDTH    = 2,
  parameter int COUNTER_WIDTH = 48,
  parameter int SATURATE      = 1,
  parameter int IDX_WIDTH     = 8
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic                           count_en,
  input  logic [N_EVENTS*INCR_WIDTH-1:0] events,
  input  logic [N_EVENTS-1:0]            clr_mask,
  input  logic                           snap_req,
  input  logic                           rd_req,
  input  logic [IDX_WIDTH-1:0]           rd_idx,
  input  logic                           rd_src,
  output logic                           rd_rsp_valid,
  output logic [IDX_WIDTH-1:0]           rd_rsp_idx,
  output logic [63:0]                    rd_rsp_data,
  output logic                           any_overflow
);

  logic [INCR_WIDTH-1:0]    r_inc_q    [N_EVENTS];
  logic [COUNTER_WIDTH-1:0] r_cnt      [N_EVENTS];
  logic [COUNTER_WIDTH-1:0] r_shadow   [N_EVENTS];
  logic [N_EVENTS-1:0]      r_ovf;
  logic [N_EVENTS-1:0]      r_shadow_ovf;
  logic [COUNTER_WIDTH:0]   w_sum      [N_EVENTS];

  logic                     r_rd_v1;
  logic [IDX_WIDTH-1:0]     r_rd_idx1;
  logic                     r_rd_src1;
  logic [63:0]              w_rd_data;

  always_comb begin
    for (int i = 0; i < N_EVENTS; i++) begin
      w_sum[i] = {1'b0, r_cnt[i]} + {{(COUNTER_WIDTH+1-INCR_WIDTH){1'b0}}, r_inc_q[i]};
    end
  end

  // Snapshot samples pre-update values, so a same-cycle clear yields read-and-clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < N_EVENTS; i++) begin
        r_inc_q[i]  <= '0;
        r_cnt[i]    <= '0;
        r_shadow[i] <= '0;
      end
      r_ovf        <= '0;
      r_shadow_ovf <= '0;
    end else begin
      for (int i = 0; i < N_EVENTS; i++) begin
        if (snap_req) begin
          r_shadow[i]     <= r_cnt[i];
          r_shadow_ovf[i] <= r_ovf[i];
        end
        if (clr_mask[i]) begin
          r_inc_q[i] <= '0;
          r_cnt[i]   <= '0;
          r_ovf[i]   <= 1'b0;
        end else begin
          r_inc_q[i] <= count_en ? events[i*INCR_WIDTH +: INCR_WIDTH] : '0;
          if (w_sum[i][COUNTER_WIDTH]) begin
            r_ovf[i] <= 1'b1;
            r_cnt[i] <= (SATURATE != 0) ? {COUNTER_WIDTH{1'b1}} : w_sum[i][COUNTER_WIDTH-1:0];
          end else begin
            r_cnt[i] <= w_sum[i][COUNTER_WIDTH-1:0];
          end
        end
      end
    end
  end

  // Out-of-range indices match no channel and read back as zero.
  always_comb begin
    w_rd_data = '0;
    for (int i = 0; i < N_EVENTS; i++) begin
      if (r_rd_idx1 == IDX_WIDTH'(i)) begin
        if (r_rd_src1) begin
          w_rd_data[63]                = r_shadow_ovf[i];
          w_rd_data[COUNTER_WIDTH-1:0] = r_shadow[i];
        end else begin
          w_rd_data[63]                = r_ovf[i];
          w_rd_data[COUNTER_WIDTH-1:0] = r_cnt[i];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rd_v1      <= 1'b0;
      r_rd_idx1    <= '0;
      r_rd_src1    <= 1'b0;
      rd_rsp_valid <= 1'b0;
      rd_rsp_idx   <= '0;
      rd_rsp_data  <= '0;
      any_overflow <= 1'b0;
    end else begin
      r_rd_v1      <= rd_req;
      r_rd_idx1    <= rd_idx;
      r_rd_src1    <= rd_src;
      rd_rsp_valid <= r_rd_v1;
      if (r_rd_v1) begin
        rd_rsp_idx  <= r_rd_idx1;
        rd_rsp_data <= w_rd_data;
      end
      any_overflow <= |r_ovf;
    end
  end

endmodule

// File: tb/tb_cci_mpf_csr_event_counter_bank.sv
// Scoreboard bench: a saturating and a wrapping 8-bit bank share one stimulus stream;
// reads push expected responses, a monitor pops and compares them.
module tb_cci_mpf_csr_event_counter_bank;
  localparam int N   = 8;
  localparam int IW  = 2;
  localparam int CW  = 8;
  localparam int IDX = 8;

  logic            clk = 1'b0;
  logic            reset_n, count_en, snap_req, rd_req, rd_src;
  logic [N*IW-1:0] events;
  logic [N-1:0]    clr_mask;
  logic [IDX-1:0]  rd_idx;

  logic            valid_s, valid_w, aovf_s, aovf_w;
  logic [IDX-1:0]  ridx_s, ridx_w;
  logic [63:0]     data_s, data_w;

  always #5 clk = ~clk;

  cci_mpf_csr_event_counter_bank #(.N_EVENTS(N), .INCR_WIDTH(IW), .COUNTER_WIDTH(CW),
    .SATURATE(1), .IDX_WIDTH(IDX)) dut_s (
    .clk(clk), .reset_n(reset_n), .count_en(count_en), .events(events),
    .clr_mask(clr_mask), .snap_req(snap_req), .rd_req(rd_req), .rd_idx(rd_idx),
    .rd_src(rd_src), .rd_rsp_valid(valid_s), .rd_rsp_idx(ridx_s),
    .rd_rsp_data(data_s), .any_overflow(aovf_s));

  cci_mpf_csr_event_counter_bank #(.N_EVENTS(N), .INCR_WIDTH(IW), .COUNTER_WIDTH(CW),
    .SATURATE(0), .IDX_WIDTH(IDX)) dut_w (
    .clk(clk), .reset_n(reset_n), .count_en(count_en), .events(events),
    .clr_mask(clr_mask), .snap_req(snap_req), .rd_req(rd_req), .rd_idx(rd_idx),
    .rd_src(rd_src), .rd_rsp_valid(valid_w), .rd_rsp_idx(ridx_w),
    .rd_rsp_data(data_w), .any_overflow(aovf_w));

  typedef struct {
    logic [IDX-1:0] idx;
    logic [63:0]    ds;
    logic [63:0]    dw;
    int             cyc;
  } exp_t;

  exp_t sbq[$];
  int   errors  = 0;
  int   checks  = 0;
  int   cyc_cnt = 0;

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%h expected 0x%h", name, act, exp);
    end
  endtask

  // Monitor: every response must match the oldest outstanding request.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (valid_s || valid_w) begin
        if (sbq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_rsp: got valid (idx %0d) expected no response", ridx_s);
        end else begin
          e = sbq.pop_front();
          chk("rsp_valid_sat",  64'(valid_s), 64'd1);
          chk("rsp_valid_wrap", 64'(valid_w), 64'd1);
          chk("rsp_cycle",      64'(cyc_cnt), 64'(e.cyc));
          chk("rsp_idx_sat",    64'(ridx_s),  64'(e.idx));
          chk("rsp_idx_wrap",   64'(ridx_w),  64'(e.idx));
          chk("rsp_data_sat",   data_s,       e.ds);
          chk("rsp_data_wrap",  data_w,       e.dw);
        end
      end
    end
  end

  task automatic cyc(input logic [N*IW-1:0] ev, input logic en, input logic [N-1:0] clr,
                     input logic snap);
    events   = ev;
    count_en = en;
    clr_mask = clr;
    snap_req = snap;
    @(posedge clk);
    #1;
    events   = '0;
    clr_mask = '0;
    snap_req = 1'b0;
    count_en = 1'b1;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic rd(input logic [IDX-1:0] idx, input logic src, input logic [63:0] es,
                    input logic [63:0] ew);
    exp_t e;
    e.idx = idx;
    e.ds  = es;
    e.dw  = ew;
    e.cyc = cyc_cnt + 2;
    sbq.push_back(e);
    rd_req = 1'b1;
    rd_idx = idx;
    rd_src = src;
    @(posedge clk);
    #1;
    rd_req = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sbq.size() != 0 && n < 20) begin
      idle(1);
      n++;
    end
    @(negedge clk);
    #1;
    checks++;
    if (sbq.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout: got %0d outstanding responses expected 0", sbq.size());
      sbq.delete();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [63:0] exp_live [10];
    exp_live = '{64'd10, 64'd0, 64'd2, 64'd9, 64'd0, 64'd1, 64'd0, 64'd0, 64'd0, 64'd0};

    reset_n  = 1'b0;
    count_en = 1'b0;
    events   = '0;
    clr_mask = '0;
    snap_req = 1'b0;
    rd_req   = 1'b0;
    rd_idx   = '0;
    rd_src   = 1'b0;
    idle(3);
    chk("reset_valid", 64'(valid_s), 64'd0);
    chk("reset_data",  data_s,       64'd0);
    chk("reset_aovf",  64'(aovf_s),  64'd0);
    reset_n  = 1'b1;
    count_en = 1'b1;
    idle(2);

    // ch0: ten single events
    repeat (10) cyc(16'h0001, 1'b1, '0, 1'b0);
    idle(2);
    rd(8'd0, 1'b0, 64'd10, 64'd10);
    drain();

    // ch3: increment 3 for four cycles, count_en low in the second
    cyc(16'h00C0, 1'b1, '0, 1'b0);
    cyc(16'h00C0, 1'b0, '0, 1'b0);
    cyc(16'h00C0, 1'b1, '0, 1'b0);
    cyc(16'h00C0, 1'b1, '0, 1'b0);
    idle(2);
    rd(8'd3, 1'b0, 64'd9, 64'd9);
    drain();

    // ch1: 300 events overflow an 8-bit counter
    repeat (300) cyc(16'h0004, 1'b1, '0, 1'b0);
    idle(2);
    chk("aovf_sat_set",  64'(aovf_s), 64'd1);
    chk("aovf_wrap_set", 64'(aovf_w), 64'd1);
    rd(8'd1, 1'b0, 64'h8000_0000_0000_00FF, 64'h8000_0000_0000_002C);
    drain();
    idle(2);
    chk("data_hold_sat", data_s,           64'h8000_0000_0000_00FF);
    chk("valid_low",     64'(valid_s),     64'd0);

    // ch2 reaches 7, then atomic snapshot+clear of ch1/ch2, then two more ch2 events
    cyc(16'h0030, 1'b1, '0, 1'b0);
    cyc(16'h0030, 1'b1, '0, 1'b0);
    cyc(16'h0010, 1'b1, '0, 1'b0);
    idle(2);
    cyc(16'h0000, 1'b1, 8'h06, 1'b1);
    chk("aovf_lag", 64'(aovf_s), 64'd1);
    cyc(16'h0010, 1'b1, '0, 1'b0);
    chk("aovf_drop_sat",  64'(aovf_s), 64'd0);
    chk("aovf_drop_wrap", 64'(aovf_w), 64'd0);
    cyc(16'h0010, 1'b1, '0, 1'b0);
    idle(2);
    rd(8'd2, 1'b1, 64'd7, 64'd7);
    rd(8'd2, 1'b0, 64'd2, 64'd2);
    rd(8'd1, 1'b1, 64'h8000_0000_0000_00FF, 64'h8000_0000_0000_002C);
    rd(8'd1, 1'b0, 64'd0, 64'd0);
    drain();

    // ch5: events before, during and after the clear cycle
    cyc(16'h0400, 1'b1, '0, 1'b0);
    cyc(16'h0400, 1'b1, 8'h20, 1'b0);
    cyc(16'h0400, 1'b1, '0, 1'b0);
    idle(2);
    rd(8'd5, 1'b0, 64'd1, 64'd1);
    drain();

    // back-to-back sweep including out-of-range indices
    for (int i = 0; i < N + 2; i++) rd(IDX'(i), 1'b0, exp_live[i], exp_live[i]);
    drain();

    // reset while reads are in flight
    rd(8'd0, 1'b0, 64'd10, 64'd10);
    rd(8'd3, 1'b0, 64'd9, 64'd9);
    reset_n = 1'b0;
    sbq.delete();
    idle(3);
    chk("midreset_valid", 64'(valid_s), 64'd0);
    chk("midreset_aovf",  64'(aovf_s),  64'd0);
    reset_n = 1'b1;
    idle(6);
    rd(8'd0, 1'b0, 64'd0, 64'd0);
    rd(8'd1, 1'b1, 64'd0, 64'd0);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
